board_ctrl: RTL and testbench

- Consumer end of the mouse/board-coordinate path. It takes the registered player-board click coordinate and the start button from the mouse controller, and maintains the player's board state. That state is 16x16 cells of 2-bit state, with only BOARD_SIZE x BOARD_SIZE used.
- Runs the ship-placement FSM. After lock, it answers enemy shots with hit/miss.
- Provides a registered read port for the board renderer.

---
 rtl/board_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_board_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Player board controller: ship placement FSM, lock/start handling, enemy shot
// resolution and a registered read port for the board renderer.
module board_ctrl #(
    parameter int BOARD_SIZE = 10,
    parameter int SHIP_CELLS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] player_cor,
    input  logic       start_btn,
    input  logic       shot_valid,
    input  logic [7:0] shot_cor,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_repeat,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [1:0] rd_data,
    output logic [4:0] placed_cnt,
    output logic       ready,
    output logic       locked,
    output logic       all_sunk
);

    localparam logic [4:0] AXIS_LIM = 5'(BOARD_SIZE);
    localparam logic [4:0] SHIP_TOT = 5'(SHIP_CELLS);

    typedef enum logic [1:0] {ST_PLACE, ST_READY, ST_LOCKED} state_e;
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_MISS  = 2'b10,
        CELL_HIT   = 2'b11
    } cell_e;

    function automatic logic in_range(input logic [3:0] x, input logic [3:0] y);
        return ({1'b0, x} < AXIS_LIM) && ({1'b0, y} < AXIS_LIM);
    endfunction

    state_e     state_q, state_d;
    cell_e      cell_q [16][16];
    logic [7:0] prev_cor_q;
    logic       prev_start_q;
    logic [4:0] placed_q, placed_d;
    logic [4:0] hits_q, hits_d;
    logic       done_q, hit_q, hit_d, rep_q, rep_d;
    logic       sunk_q, sunk_d;
    logic [1:0] rd_q;

    logic [3:0] click_x, click_y, shot_x, shot_y;
    logic       click_ev, start_ev;
    cell_e      click_cell, shot_cell;
    logic       we;
    logic [3:0] wx, wy;
    cell_e      wd;

    assign click_x    = player_cor[7:4];
    assign click_y    = player_cor[3:0];
    assign shot_x     = shot_cor[7:4];
    assign shot_y     = shot_cor[3:0];
    // A click is the transition from "no click" to a valid coordinate, so a
    // held button or a drag while held never produces a second event.
    assign click_ev   = (prev_cor_q == 8'hff) && (player_cor != 8'hff) &&
                        in_range(click_x, click_y);
    assign start_ev   = start_btn && !prev_start_q;
    assign click_cell = cell_q[click_x][click_y];
    assign shot_cell  = cell_q[shot_x][shot_y];

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        placed_d = placed_q;
        hits_d   = hits_q;
        we       = 1'b0;
        wx       = click_x;
        wy       = click_y;
        wd       = CELL_EMPTY;
        hit_d    = 1'b0;
        rep_d    = 1'b0;

        case (state_q)
            ST_PLACE: begin
                if (click_ev) begin
                    if (click_cell == CELL_EMPTY && placed_q < SHIP_TOT) begin
                        we       = 1'b1;
                        wd       = CELL_SHIP;
                        placed_d = placed_q + 5'd1;
                    end else if (click_cell == CELL_SHIP) begin
                        we       = 1'b1;
                        wd       = CELL_EMPTY;
                        placed_d = placed_q - 5'd1;
                    end
                end
                if (placed_d == SHIP_TOT) state_d = ST_READY;
                rep_d = shot_valid;
            end
            ST_READY: begin
                // A click that removes a ship wins over a simultaneous start.
                if (click_ev && click_cell == CELL_SHIP) begin
                    we       = 1'b1;
                    wd       = CELL_EMPTY;
                    placed_d = placed_q - 5'd1;
                    state_d  = ST_PLACE;
                end else if (start_ev) begin
                    state_d = ST_LOCKED;
                end
                rep_d = shot_valid;
            end
            ST_LOCKED: begin
                if (shot_valid) begin
                    wx = shot_x;
                    wy = shot_y;
                    if (!in_range(shot_x, shot_y)) begin
                        rep_d = 1'b1;
                    end else begin
                        case (shot_cell)
                            CELL_SHIP: begin
                                we     = 1'b1;
                                wd     = CELL_HIT;
                                hit_d  = 1'b1;
                                hits_d = hits_q + 5'd1;
                            end
                            CELL_EMPTY: begin
                                we = 1'b1;
                                wd = CELL_MISS;
                            end
                            default: rep_d = 1'b1;
                        endcase
                    end
                end
            end
            default: state_d = ST_PLACE;
        endcase

        sunk_d = sunk_q || (state_q == ST_LOCKED && hits_q == SHIP_TOT);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PLACE;
            prev_cor_q   <= 8'hff;
            prev_start_q <= 1'b0;
            placed_q     <= '0;
            hits_q       <= '0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            rep_q        <= 1'b0;
            sunk_q       <= 1'b0;
            rd_q         <= CELL_EMPTY;
        end else begin
            state_q      <= state_d;
            prev_cor_q   <= player_cor;
            prev_start_q <= start_btn;
            placed_q     <= placed_d;
            hits_q       <= hits_d;
            done_q       <= shot_valid;
            hit_q        <= hit_d;
            rep_q        <= rep_d;
            sunk_q       <= sunk_d;
            rd_q         <= in_range(rd_x, rd_y) ? cell_q[rd_x][rd_y] : CELL_EMPTY;
        end
    end

    // NOTE: the board lives in flops rather than a RAM because a reset must
    // clear every cell in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    cell_q[x][y] <= CELL_EMPTY;
                end
            end
        end else if (we) begin
            cell_q[wx][wy] <= wd;
        end
    end

    assign shot_done   = done_q;
    assign shot_hit    = hit_q;
    assign shot_repeat = rep_q;
    assign rd_data     = rd_q;
    assign placed_cnt  = placed_q;
    assign ready       = (state_q == ST_READY);
    assign locked      = (state_q == ST_LOCKED);
    assign all_sunk    = sunk_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: table-driven click vectors, hand-written
// start/lock/reset sequences and a scoreboard for shot responses.
module tb_board_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] player_cor = 8'hff;
    logic       start_btn = 1'b0;
    logic       shot_valid = 1'b0;
    logic [7:0] shot_cor = 8'h00;
    logic       shot_done, shot_hit, shot_repeat;
    logic [3:0] rd_x = 4'd0;
    logic [3:0] rd_y = 4'd0;
    logic [1:0] rd_data;
    logic [4:0] placed_cnt;
    logic       ready, locked, all_sunk;

    always #5 clk = ~clk;

    board_ctrl #(.BOARD_SIZE(10), .SHIP_CELLS(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .player_cor (player_cor),
        .start_btn  (start_btn),
        .shot_valid (shot_valid),
        .shot_cor   (shot_cor),
        .shot_done  (shot_done),
        .shot_hit   (shot_hit),
        .shot_repeat(shot_repeat),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .placed_cnt (placed_cnt),
        .ready      (ready),
        .locked     (locked),
        .all_sunk   (all_sunk)
    );

    typedef struct {
        logic [7:0] cor;
        int         cnt;
        logic       rdy;
    } vec_t;

    typedef struct {
        int   due;
        logic hit;
        logic rep;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic click(input logic [7:0] c);
        player_cor = c;
        tick();
        player_cor = 8'hff;
        tick();
    endtask

    task automatic read_cell(input logic [3:0] x, input logic [3:0] y,
                             input logic [1:0] exp, input string name);
        rd_x = x;
        rd_y = y;
        tick();
        check(name, rd_data, exp);
    endtask

    task automatic shoot(input logic [7:0] c, input logic hit, input logic rep);
        shot_cor   = c;
        shot_valid = 1'b1;
        sb.push_back('{due: cyc + 1, hit: hit, rep: rep});
        tick();
        shot_valid = 1'b0;
    endtask

    // Shot response monitor: each strobe must be answered exactly one cycle later.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("shot_done", shot_done, 1'b1);
            check("shot_hit", shot_hit, e.hit);
            check("shot_repeat", shot_repeat, e.rep);
        end else if (shot_done === 1'b1) begin
            check("shot_done_unexpected", shot_done, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{cor: 8'h23, cnt: 0, rdy: 1'b0});
        vecs.push_back('{cor: 8'hA0, cnt: 0, rdy: 1'b0});
        vecs.push_back('{cor: 8'h0A, cnt: 0, rdy: 1'b0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{cor: {4'(i), 4'd1}, cnt: i + 1, rdy: 1'b0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{cor: {4'(i), 4'd2}, cnt: i + 11, rdy: (i == 9)});
        vecs.push_back('{cor: 8'h55, cnt: 20, rdy: 1'b1});
        vecs.push_back('{cor: 8'h02, cnt: 19, rdy: 1'b0});

        // Reset state
        repeat (3) tick();
        check("rst_placed_cnt", placed_cnt, 5'd0);
        check("rst_ready", ready, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_all_sunk", all_sunk, 1'b0);
        check("rst_shot_done", shot_done, 1'b0);
        check("rst_rd_data", rd_data, 2'b00);
        rst = 1'b0;
        tick();

        // Held click yields one event
        player_cor = 8'h23;
        repeat (5) tick();
        player_cor = 8'hff;
        tick();
        check("held_click_cnt", placed_cnt, 5'd1);
        read_cell(4'd2, 4'd3, 2'b01, "held_click_cell");

        // Shot before lock is rejected and writes nothing
        shoot(8'h23, 1'b0, 1'b1);
        read_cell(4'd2, 4'd3, 2'b01, "early_shot_cell");

        // Placement vectors
        foreach (vecs[i]) begin
            click(vecs[i].cor);
            check($sformatf("vec%0d_cnt", i), placed_cnt, vecs[i].cnt);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].rdy);
        end
        read_cell(4'd2, 4'd3, 2'b00, "deselect_cell");
        read_cell(4'd5, 4'd5, 2'b00, "ready_empty_click_cell");

        // Start held during PLACE does not lock
        start_btn = 1'b1;
        repeat (3) tick();
        check("place_start_locked", locked, 1'b0);
        start_btn = 1'b0;
        tick();
        click(8'h02);
        check("refill_ready", ready, 1'b1);

        // Click on a ship and start in the same cycle: start dropped
        player_cor = 8'h02;
        start_btn  = 1'b1;
        tick();
        player_cor = 8'hff;
        start_btn  = 1'b0;
        tick();
        check("click_start_cnt", placed_cnt, 5'd19);
        check("click_start_locked", locked, 1'b0);
        check("click_start_ready", ready, 1'b0);
        click(8'h02);
        check("refill2_ready", ready, 1'b1);

        // Click on an empty cell and start together: start taken
        player_cor = 8'h55;
        start_btn  = 1'b1;
        tick();
        player_cor = 8'hff;
        start_btn  = 1'b0;
        tick();
        check("lock_locked", locked, 1'b1);
        check("lock_ready", ready, 1'b0);
        check("lock_cnt", placed_cnt, 5'd20);

        // Clicks while locked change nothing
        click(8'h33);
        click(8'h01);
        check("locked_click_cnt", placed_cnt, 5'd20);
        read_cell(4'd3, 4'd3, 2'b00, "locked_click_empty");
        read_cell(4'd0, 4'd1, 2'b01, "locked_click_ship");

        // Shot resolution
        shoot(8'h11, 1'b1, 1'b0);
        read_cell(4'd1, 4'd1, 2'b11, "hit_cell");
        shoot(8'h11, 1'b0, 1'b1);
        shoot(8'h55, 1'b0, 1'b0);
        read_cell(4'd5, 4'd5, 2'b10, "miss_cell");
        shoot(8'hA0, 1'b0, 1'b1);
        check("sunk_early", all_sunk, 1'b0);

        // Remaining ships, one shot per cycle
        shot_valid = 1'b1;
        for (int y = 1; y <= 2; y++) begin
            for (int x = 0; x < 10; x++) begin
                if (!(x == 1 && y == 1)) begin
                    shot_cor = {4'(x), 4'(y)};
                    sb.push_back('{due: cyc + 1, hit: 1'b1, rep: 1'b0});
                    tick();
                end
            end
        end
        shot_valid = 1'b0;
        check("sunk_with_last_done", all_sunk, 1'b0);
        tick();
        check("sunk_after_last_done", all_sunk, 1'b1);
        tick();
        check("sunk_sticky", all_sunk, 1'b1);

        // Reset mid-game clears a pending response and the board
        rd_x = 4'd1;
        rd_y = 4'd1;
        shoot(8'h92, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_shot_done", shot_done, 1'b0);
        check("midrst_shot_hit", shot_hit, 1'b0);
        check("midrst_shot_repeat", shot_repeat, 1'b0);
        check("midrst_locked", locked, 1'b0);
        check("midrst_ready", ready, 1'b0);
        check("midrst_all_sunk", all_sunk, 1'b0);
        check("midrst_placed_cnt", placed_cnt, 5'd0);
        check("midrst_rd_data", rd_data, 2'b00);
        rst = 1'b0;
        read_cell(4'd1, 4'd1, 2'b00, "midrst_cell_11");
        read_cell(4'd5, 4'd5, 2'b00, "midrst_cell_55");
        read_cell(4'd0, 4'd2, 2'b00, "midrst_cell_02");

        repeat (2) tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
